// File: rtl/cursor_pkg.sv
// Shared scan codes, repeat-FSM states and move directions for the cursor controller.
package cursor_pkg;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } repeat_state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_LEFT,
        DIR_DOWN,
        DIR_RIGHT
    } dir_t;

    // Non-direction codes (including SPACE) map to DIR_NONE.
    function automatic dir_t decode_dir(input logic [7:0] code);
        case (code)
            KEY_W:   return DIR_UP;
            KEY_A:   return DIR_LEFT;
            KEY_S:   return DIR_DOWN;
            KEY_D:   return DIR_RIGHT;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cursor_ctrl_if.sv
// Keyboard input / cursor output bundle between hps_io, cursor_ctrl and pixel_selector.
interface cursor_ctrl_if;

    logic [10:0] ps2_key;
    logic        frame_start;
    logic [10:0] cursor_x;
    logic [3:0]  cursor_y;
    logic        cursor_clicked;

    modport master (
        output ps2_key,
        output frame_start,
        input  cursor_x,
        input  cursor_y,
        input  cursor_clicked
    );

    modport slave (
        input  ps2_key,
        input  frame_start,
        output cursor_x,
        output cursor_y,
        output cursor_clicked
    );

endinterface

// File: rtl/key_repeat_timer.sv
// Hold-to-repeat FSM: one move per press, then repeats after REPEAT_DELAY and every REPEAT_RATE.
module key_repeat_timer
    import cursor_pkg::*;
#(
    parameter int REPEAT_DELAY = 24_000_000,
    parameter int REPEAT_RATE  = 2_400_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_press,
    input  logic key_release,
    input  dir_t key_dir,
    output logic move_strobe,
    output dir_t held
);

    localparam int CW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

    repeat_state_t state;
    logic [CW-1:0] count;

    logic new_press;
    logic release_held;
    logic expired;

    // A re-press of the key already held (typematic) is not a new direction.
    always_comb begin
        new_press    = key_press && ((state == IDLE) || (key_dir != held));
        release_held = key_release && (state != IDLE) && (key_dir == held);
        expired      = (state != IDLE) && (count == '0) && !new_press && !release_held;
        move_strobe  = new_press || expired;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            held  <= DIR_NONE;
        end else if (new_press) begin
            state <= DELAY;
            count <= DELAY_LOAD;
            held  <= key_dir;
        end else if (release_held) begin
            state <= IDLE;
            count <= '0;
            held  <= DIR_NONE;
        end else if (state != IDLE) begin
            if (count == '0) begin
                state <= REPEAT;
                count <= RATE_LOAD;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cursor_ctrl.sv
// Keyboard cursor controller: decodes ps2_key events, moves a clamped shadow cursor and
// publishes it, plus a one-frame click pulse, only at frame boundaries.
module cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 1279,
    parameter int Y_MAX        = 9,
    parameter int X_INIT       = 100,
    parameter int Y_INIT       = 0,
    parameter int REPEAT_DELAY = 24_000_000,
    parameter int REPEAT_RATE  = 2_400_000
) (
    input logic          clk,
    input logic          reset,
    cursor_ctrl_if.slave bus
);

    localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [4:0]  Y_MAX_S = 5'(Y_MAX);

    logic        old_toggle;
    logic        key_valid;
    dir_t        key_dir;
    logic        dir_press;
    logic        dir_release;
    logic        space_press;
    logic        move_strobe;
    dir_t        held;
    dir_t        move_dir;

    logic [10:0] sx;
    logic [3:0]  sy;
    logic        click_pend;

    logic signed [11:0] x_step;
    logic signed [4:0]  y_step;
    logic signed [11:0] x_wide;
    logic signed [4:0]  y_wide;
    logic [10:0]        x_next;
    logic [3:0]         y_next;

    // Extended codes are dropped before any decoding.
    always_comb begin
        key_valid   = (bus.ps2_key[10] ^ old_toggle) && !bus.ps2_key[8];
        key_dir     = decode_dir(bus.ps2_key[7:0]);
        dir_press   = key_valid && bus.ps2_key[9] && (key_dir != DIR_NONE);
        dir_release = key_valid && !bus.ps2_key[9] && (key_dir != DIR_NONE);
        space_press = key_valid && bus.ps2_key[9] && (bus.ps2_key[7:0] == KEY_SPACE);
    end

    key_repeat_timer #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .key_press   (dir_press),
        .key_release (dir_release),
        .key_dir     (key_dir),
        .move_strobe (move_strobe),
        .held        (held)
    );

    // A press moves in the freshly pressed direction; an expiry repeats the held one.
    always_comb begin
        move_dir = dir_press ? key_dir : held;
        x_step   = '0;
        y_step   = '0;
        if (move_strobe) begin
            case (move_dir)
                DIR_UP:    y_step = -5'sd1;
                DIR_DOWN:  y_step = 5'sd1;
                DIR_LEFT:  x_step = -12'sd1;
                DIR_RIGHT: x_step = 12'sd1;
                default: ;
            endcase
        end

        x_wide = $signed({1'b0, sx}) + x_step;
        y_wide = $signed({1'b0, sy}) + y_step;

        if (x_wide < X_MIN_S)
            x_next = X_MIN_S[10:0];
        else if (x_wide > X_MAX_S)
            x_next = X_MAX_S[10:0];
        else
            x_next = x_wide[10:0];

        if (y_wide < 5'sd0)
            y_next = '0;
        else if (y_wide > Y_MAX_S)
            y_next = Y_MAX_S[3:0];
        else
            y_next = y_wide[3:0];
    end

    // Outputs sample the shadow state before this cycle's move, so a same-cycle
    // event shows up one frame later.
    always_ff @(posedge clk) begin
        if (reset) begin
            old_toggle         <= bus.ps2_key[10];
            sx                 <= 11'(X_INIT);
            sy                 <= 4'(Y_INIT);
            click_pend         <= 1'b0;
            bus.cursor_x       <= 11'(X_INIT);
            bus.cursor_y       <= 4'(Y_INIT);
            bus.cursor_clicked <= 1'b0;
        end else begin
            old_toggle <= bus.ps2_key[10];
            sx         <= x_next;
            sy         <= y_next;
            if (bus.frame_start) begin
                bus.cursor_x       <= sx;
                bus.cursor_y       <= sy;
                bus.cursor_clicked <= click_pend;
                click_pend         <= space_press;
            end else if (space_press) begin
                click_pend <= 1'b1;
            end
        end
    end

endmodule
